// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: FIFO geometry, header field bounds and tag position.
// Used by the FIFOs, the register stage and the router FSM.
package router_pkg;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_ADDR_W = 4;

  // Header byte layout: [7:2] payload length, [1:0] destination address
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam int TAG_BIT = FIFO_WIDTH;
  localparam int PKT_W   = 7;
endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for one router output FIFO: one write port, one
// combinational read port, and a synchronous clear-all alongside the async reset.
module router_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // clear wins over a same-cycle write so a flush never leaves a stray word behind
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Tags each byte as header or not,
// tracks remaining packet length on the read side, and blanks data_out between packets.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);
  // Handshake: a write is accepted on a rising edge when write_enb && !full, a read
  // when read_enb && !empty; flags are judged on pre-edge pointers, rejected requests are dropped.
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [PKT_W-1:0] pkt_count;
  logic [WIDTH:0]   rd_word;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_wr = write_enb && !full;
  assign do_rd = read_enb && !empty;

  router_fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH + 1),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (soft_reset),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
    end else if (do_wr) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_out  <= '0;
    end else if (soft_reset) begin
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_out  <= '0;
    end else if (do_rd) begin
      rd_ptr   <= rd_ptr + 1'b1;
      data_out <= rd_word[WIDTH-1:0];
      // header reload counts the payload bytes plus the trailing parity byte
      if (rd_word[TAG_BIT])
        pkt_count <= {1'b0, rd_word[LEN_MSB:LEN_LSB]} + 1'b1;
      else if (pkt_count != '0)
        pkt_count <= pkt_count - 1'b1;
    end else if (pkt_count == '0) begin
      data_out <= '0;
    end
  end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_router_fifo;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full, empty;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];
  int         m_pkt = 0;
  logic [7:0] m_dout = 8'h00;

  always @(negedge resetn) begin
    exp_q.delete();
    m_pkt  = 0;
    m_dout = 8'h00;
  end

  always @(posedge clock) begin
    if (resetn) begin
      if (soft_reset) begin
        exp_q.delete();
        m_pkt  = 0;
        m_dout = 8'h00;
      end else begin
        bit         can_rd, can_wr;
        logic [8:0] w;
        can_rd = read_enb  && (exp_q.size() != 0);
        can_wr = write_enb && (exp_q.size() != DEPTH);
        if (can_rd) begin
          w = exp_q.pop_front();
          m_dout = w[7:0];
          if (w[8]) m_pkt = int'(w[7:2]) + 1;
          else if (m_pkt != 0) m_pkt = m_pkt - 1;
        end else if (m_pkt == 0) begin
          m_dout = 8'h00;
        end
        if (can_wr) exp_q.push_back({lfd_state, data_in});
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      total++;
      if (empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH) ||
          data_out !== m_dout) begin
        bad++;
        $display("FAIL model t=%0t: got full=%b empty=%b data_out=%h, need full=%b empty=%b data_out=%h",
                 $time, full, empty, data_out, exp_q.size() == DEPTH, exp_q.size() == 0, m_dout);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs; returns just after the following falling edge
  task automatic cyc(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                     input bit sr = 1'b0);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    @(negedge clock);
    #1;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    soft_reset = 1'b0;
  endtask

  initial begin
    // 1: async reset, no clock edge needed
    #3 resetn = 1'b0;
    #1;
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full",  {7'd0, full},  8'h00);
    chk("rst_dout",  data_out,      8'h00);
    chk_en = 1'b1;
    @(negedge clock);
    #1 resetn = 1'b1;
    cyc(0, 0, 0, 8'h00);

    // 2: one packet, len 3
    cyc(1, 0, 1, 8'h0E);
    cyc(1, 0, 0, 8'hA1);
    cyc(1, 0, 0, 8'hA2);
    cyc(1, 0, 0, 8'hA3);
    cyc(1, 0, 0, 8'h5C);
    cyc(0, 1, 0, 8'h00); chk("pkt_hdr", data_out, 8'h0E);
    cyc(0, 1, 0, 8'h00); chk("pkt_p1",  data_out, 8'hA1);
    cyc(0, 1, 0, 8'h00); chk("pkt_p2",  data_out, 8'hA2);
    cyc(0, 1, 0, 8'h00); chk("pkt_p3",  data_out, 8'hA3);
    cyc(0, 1, 0, 8'h00); chk("pkt_par", data_out, 8'h5C);
    cyc(0, 0, 0, 8'h00);
    chk("pkt_clear", data_out, 8'h00);
    chk("pkt_empty", {7'd0, empty}, 8'h01);

    // 3: fill and overflow
    for (int i = 1; i <= 16; i++) cyc(1, 0, 0, 8'(i));
    chk("fill_full", {7'd0, full}, 8'h01);
    cyc(1, 0, 0, 8'h11);
    chk("ovf_full", {7'd0, full}, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 8'h00);
      if (i == 1)  chk("drain_first", data_out, 8'h01);
      if (i == 16) chk("drain_last",  data_out, 8'h10);
    end
    chk("drain_empty", {7'd0, empty}, 8'h01);
    cyc(0, 0, 0, 8'h00);

    // 4: simultaneous read/write at full, then at empty
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'h20 + 8'(i));
    cyc(1, 1, 0, 8'h99);
    chk("rw_full_clr", {7'd0, full}, 8'h00);
    chk("rw_full_rd",  data_out, 8'h20);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00);
    chk("rw_lost", data_out, 8'h2F);
    chk("rw_drained", {7'd0, empty}, 8'h01);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 1, 0, 8'h77);
    chk("rw_empty_wr", {7'd0, empty}, 8'h00);
    chk("rw_empty_dout", data_out, 8'h00);
    cyc(0, 1, 0, 8'h00);
    chk("rw_empty_rd", data_out, 8'h77);
    cyc(0, 0, 0, 8'h00);

    // 5: wrap-around with continuous data
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'h40 + 8'(r * 10 + i));
      for (int i = 0; i < 10; i++) begin
        cyc(0, 1, 0, 8'h00);
        chk("wrap_data", data_out, 8'h40 + 8'(r * 10 + i));
      end
    end
    chk("wrap_empty", {7'd0, empty}, 8'h01);
    cyc(0, 0, 0, 8'h00);

    // 6: soft_reset mid-packet, then a fresh packet (len 1)
    cyc(1, 0, 1, 8'h10);
    cyc(1, 0, 0, 8'hB1);
    cyc(1, 0, 0, 8'hB2);
    cyc(0, 1, 0, 8'h00);
    chk("sr_hdr", data_out, 8'h10);
    cyc(1, 1, 0, 8'hB3, 1'b1);
    chk("sr_empty", {7'd0, empty}, 8'h01);
    chk("sr_full",  {7'd0, full},  8'h00);
    chk("sr_dout",  data_out,      8'h00);
    cyc(1, 0, 1, 8'h04);
    cyc(1, 0, 0, 8'hC1);
    cyc(1, 0, 0, 8'hC3);
    cyc(0, 1, 0, 8'h00); chk("new_hdr", data_out, 8'h04);
    cyc(0, 1, 0, 8'h00); chk("new_p1",  data_out, 8'hC1);
    cyc(0, 1, 0, 8'h00); chk("new_par", data_out, 8'hC3);
    cyc(0, 0, 0, 8'h00); chk("new_clear", data_out, 8'h00);
    cyc(0, 0, 0, 8'h00);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
